// File: rtl/psum_acc_bank_pkg.sv
// Shared types and default sizes for the partial-sum accumulation bank.
package psum_acc_bank_pkg;

  localparam int unsigned DefNumMac    = 3;
  localparam int unsigned DefPsumWidth = 24;
  localparam int unsigned DefAddrWidth = 5;
  localparam int unsigned DefDepth     = 16;

  typedef enum logic {
    StAcc   = 1'b0,
    StDrain = 1'b1
  } acc_state_e;

endpackage

// File: rtl/psum_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after the pointer.
module psum_rr_arb #(
  parameter int unsigned NUM_MAC = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [NUM_MAC-1:0] val,
  output logic [NUM_MAC-1:0] gnt
);

  localparam int unsigned PtrW = (NUM_MAC > 1) ? $clog2(NUM_MAC) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned c;
    c     = 0;
    gnt   = '0;
    ptr_d = ptr_q;
    for (int unsigned k = 0; k < NUM_MAC; k++) begin
      c = (32'(ptr_q) + k) % NUM_MAC;
      if (en && val[c] && (gnt == '0)) begin
        gnt[c] = 1'b1;
        ptr_d  = PtrW'((c + 1) % NUM_MAC);
      end
    end
    if (clr) ptr_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/psum_acc_bank.sv
// Accumulates MAC partial sums into a flop bank and drains the finished row in address order.
module psum_acc_bank
  import psum_acc_bank_pkg::*;
#(
  parameter int unsigned NUM_MAC    = DefNumMac,
  parameter int unsigned PSUM_WIDTH = DefPsumWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DEPTH      = DefDepth,
  localparam int unsigned IdxW      = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic [NUM_MAC-1:0]            mac_val,
  input  logic [NUM_MAC*ADDR_WIDTH-1:0] mac_addr,
  input  logic [NUM_MAC*PSUM_WIDTH-1:0] mac_psum,
  output logic [NUM_MAC-1:0]            mac_rdy,
  input  logic                          drain_req,
  output logic                          drain_busy,
  output logic                          out_val,
  output logic [IdxW-1:0]               out_addr,
  output logic [PSUM_WIDTH-1:0]         out_psum,
  input  logic                          out_rdy,
  output logic [7:0]                    drop_cnt
);

  acc_state_e            state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [7:0]            drop_q, drop_d;
  logic [PSUM_WIDTH-1:0] bank_q [DEPTH];
  logic [PSUM_WIDTH-1:0] bank_d [DEPTH];

  logic                  arb_en;
  logic                  accept;
  logic                  in_range;
  logic                  drain_hs;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [PSUM_WIDTH-1:0] sel_psum;

  // Grants are masked during reset and clear so no psum is consumed and then lost.
  assign arb_en = rst_n && !clr && (state_q == StAcc);

  psum_rr_arb #(
    .NUM_MAC (NUM_MAC)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (arb_en),
    .val   (mac_val),
    .gnt   (mac_rdy)
  );

  always_comb begin
    sel_addr = '0;
    sel_psum = '0;
    for (int i = 0; i < NUM_MAC; i++) begin
      if (mac_rdy[i]) begin
        sel_addr = mac_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_psum = mac_psum[i*PSUM_WIDTH +: PSUM_WIDTH];
      end
    end
  end

  assign accept   = |mac_rdy;
  assign in_range = 32'(sel_addr) < DEPTH;

  assign out_val    = (state_q == StDrain);
  assign drain_busy = out_val;
  assign out_addr   = idx_q;
  assign out_psum   = out_val ? bank_q[idx_q] : '0;
  assign drain_hs   = out_val && out_rdy;
  assign drop_cnt   = drop_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StAcc: begin
        if (drain_req) state_d = StDrain;
      end
      StDrain: begin
        if (out_rdy) begin
          if (idx_q == IdxW'(DEPTH - 1)) begin
            state_d = StAcc;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StAcc;
    endcase
    if (clr) begin
      state_d = StAcc;
      idx_d   = '0;
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (accept && !in_range && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) bank_d[i] = bank_q[i];
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) bank_d[i] = '0;
    end else begin
      // Reads come straight from bank_q, so back-to-back same-address accepts chain correctly.
      if (accept && in_range) begin
        bank_d[sel_addr[IdxW-1:0]] = bank_q[sel_addr[IdxW-1:0]] + sel_psum;
      end
      if (drain_hs) bank_d[idx_q] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAcc;
      idx_q   <= '0;
      drop_q  <= '0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= bank_d[i];
    end
  end

endmodule

// File: tb/tb_psum_acc_bank.sv
// Directed-vector bench for psum_acc_bank.
module tb_psum_acc_bank;

  localparam int Depth = 16;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [2:0]  mac_val;
  logic [14:0] mac_addr;
  logic [71:0] mac_psum;
  logic [2:0]  mac_rdy;
  logic        drain_req;
  logic        drain_busy;
  logic        out_val;
  logic [3:0]  out_addr;
  logic [23:0] out_psum;
  logic        out_rdy;
  logic [7:0]  drop_cnt;

  int total;
  int bad;
  logic [23:0] exp_bank [Depth];

  psum_acc_bank dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .mac_val    (mac_val),
    .mac_addr   (mac_addr),
    .mac_psum   (mac_psum),
    .mac_rdy    (mac_rdy),
    .drain_req  (drain_req),
    .drain_busy (drain_busy),
    .out_val    (out_val),
    .out_addr   (out_addr),
    .out_psum   (out_psum),
    .out_rdy    (out_rdy),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one MAC with a single psum and check the combinational grant.
  task automatic put(input int m, input logic [4:0] a, input logic [23:0] p,
                     input logic [2:0] exp_rdy);
    @(negedge clk);
    mac_val = 3'b000;
    mac_val[m] = 1'b1;
    mac_addr[m*5 +: 5] = a;
    mac_psum[m*24 +: 24] = p;
    #1 chk("put_rdy", {29'd0, mac_rdy}, {29'd0, exp_rdy});
  endtask

  task automatic idle();
    @(negedge clk);
    mac_val = 3'b000;
  endtask

  // mode 0: out_rdy always high; mode 1: out_rdy pattern 1,0,0 repeating.
  task automatic drain(input int mode);
    int n;
    int cyc;
    n = 0;
    cyc = 0;
    @(negedge clk);
    mac_val = 3'b000;
    drain_req = 1'b1;
    out_rdy = 1'b0;
    #1 chk("pre_drain_val", {31'd0, out_val}, 32'd0);
    @(negedge clk);
    drain_req = 1'b0;
    while (n < Depth && cyc < 200) begin
      out_rdy = (mode == 0) || (cyc % 3 == 0);
      #1;
      chk("drain_val", {31'd0, out_val}, 32'd1);
      chk("drain_addr", {28'd0, out_addr}, n);
      chk("drain_psum", {8'd0, out_psum}, {8'd0, exp_bank[n]});
      if (out_val && out_rdy) n++;
      cyc++;
      @(negedge clk);
    end
    out_rdy = 1'b0;
    chk("drain_count", n, Depth);
    #1 chk("drain_done", {31'd0, drain_busy}, 32'd0);
    for (int i = 0; i < Depth; i++) exp_bank[i] = '0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < Depth; i++) exp_bank[i] = '0;
    rst_n = 1'b0;
    clr = 1'b0;
    mac_val = '0;
    mac_addr = '0;
    mac_psum = '0;
    drain_req = 1'b0;
    out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", {29'd0, mac_rdy}, 32'd0);
    chk("rst_val", {31'd0, out_val}, 32'd0);
    chk("rst_addr", {28'd0, out_addr}, 32'd0);
    chk("rst_psum", {8'd0, out_psum}, 32'd0);
    chk("rst_busy", {31'd0, drain_busy}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
    rst_n = 1'b1;

    // 1: MAC0 fills every entry with i+1, then a full-speed drain.
    for (int i = 0; i < Depth; i++) begin
      put(0, 5'(i), 24'(i + 1), 3'b001);
      exp_bank[i] = 24'(i + 1);
    end
    drain(0);

    // 2: all MACs at addr 5; pointer reset by a clear first.
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    mac_val = 3'b111;
    mac_addr = {5'd5, 5'd5, 5'd5};
    mac_psum = {24'd30, 24'd20, 24'd10};
    #1 chk("rr_gnt0", {29'd0, mac_rdy}, 32'b001);
    @(negedge clk);
    #1 chk("rr_gnt1", {29'd0, mac_rdy}, 32'b010);
    @(negedge clk);
    #1 chk("rr_gnt2", {29'd0, mac_rdy}, 32'b100);
    @(negedge clk);
    #1 chk("rr_gnt3", {29'd0, mac_rdy}, 32'b001);
    mac_val = 3'b000;
    exp_bank[5] = 24'd60;

    // 3: out-of-range addresses are accepted and dropped.
    @(negedge clk);
    mac_val = 3'b110;
    mac_addr = {5'h1F, 5'd16, 5'd0};
    mac_psum = {24'd99, 24'd7, 24'd0};
    #1 chk("drop_gnt1", {29'd0, mac_rdy}, 32'b010);
    @(negedge clk);
    #1 chk("drop_gnt2", {29'd0, mac_rdy}, 32'b100);
    @(negedge clk);
    mac_val = 3'b000;
    #1 chk("drop_cnt2", {24'd0, drop_cnt}, 32'd2);

    // 4: stalled drain; checks 60 at addr 5 and zeros left by the first drain.
    drain(1);

    // 5: clear aborts a drain after three entries.
    for (int i = 0; i < Depth; i++) put(0, 5'(i), 24'(i + 100), 3'b001);
    idle();
    drain_req = 1'b1;
    @(negedge clk);
    drain_req = 1'b0;
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("abort_psum", {8'd0, out_psum}, i + 100);
      @(negedge clk);
    end
    out_rdy = 1'b0;
    clr = 1'b1;
    mac_val = 3'b001;
    mac_addr = 15'd0;
    mac_psum = 72'd5;
    #1 chk("clr_rdy", {29'd0, mac_rdy}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    mac_val = 3'b000;
    #1;
    chk("clr_val", {31'd0, out_val}, 32'd0);
    chk("clr_busy", {31'd0, drain_busy}, 32'd0);
    chk("clr_drop", {24'd0, drop_cnt}, 32'd2);
    drain(0);

    // 6: wrap without saturation, then reset during an accept.
    put(0, 5'd0, 24'h7FFFFF, 3'b001);
    put(0, 5'd0, 24'h000001, 3'b001);
    exp_bank[0] = 24'h800000;
    drain(0);
    put(0, 5'd3, 24'd55, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("rst2_rdy", {29'd0, mac_rdy}, 32'd0);
    chk("rst2_val", {31'd0, out_val}, 32'd0);
    chk("rst2_addr", {28'd0, out_addr}, 32'd0);
    chk("rst2_psum", {8'd0, out_psum}, 32'd0);
    chk("rst2_busy", {31'd0, drain_busy}, 32'd0);
    chk("rst2_drop", {24'd0, drop_cnt}, 32'd0);
    @(negedge clk);
    mac_val = 3'b000;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
